word_round_ctrl: RTL

Round controller for the letter-guessing game; it drives the other end of the `ascii_comparor` interface. It holds a secret word, accepts one guessed ASCII letter at a time, and walks the word position by position. For each position it presents `ascii` (the guess) and `selection` (the secret letter) to the comparator, then samples the comparator's `set`/`wrong` verdict. From these verdicts it maintains the revealed-letter mask and miss count, and declares win or lose.

---
 rtl/word_round_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/word_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : word_round_ctrl
// Description : Letter-guessing round controller; scans a guess against the
//               secret word through an external comparator and tracks
//               revealed letters, misses and win/lose.
//               Optional: WORD_ROUND_CASE_FOLD_EN folds A-Z guesses to a-z.
// Revision    : 1.0
// ============================================================================
module word_round_ctrl #(
    parameter int WORD_LEN   = 5,
    parameter int MAX_MISSES = 6,
    parameter int CMP_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  word_load,
    input  logic [7*WORD_LEN-1:0] word_in,
    input  logic                  guess_valid,
    input  logic [6:0]            guess_ascii,
    output logic                  guess_ready,
    output logic [6:0]            ascii,
    output logic [6:0]            selection,
    input  logic                  cmp_set,
    input  logic                  cmp_wrong,
    output logic [WORD_LEN-1:0]   revealed,
    output logic [3:0]            miss_count,
    output logic                  win,
    output logic                  lose,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_READY = 3'd1,
        S_SCAN  = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] c_lat_last = 2'(CMP_LAT);
    localparam logic [2:0] c_idx_last = 3'(WORD_LEN - 1);
    localparam logic [3:0] c_max_miss = 4'(MAX_MISSES);

    state_t                r_state, w_state_next;
    logic [7*WORD_LEN-1:0] r_word;
    logic [6:0]            r_guess;
    logic [2:0]            r_idx;
    logic [1:0]            r_lat_cnt;
    logic                  r_hit;
    logic [WORD_LEN-1:0]   r_revealed;
    logic [3:0]            r_miss;
    logic                  r_win, r_lose;

    logic [6:0] w_guess_in;
    logic [6:0] w_sel;
    logic       w_accept, w_sample, w_pos_hit, w_all;
    logic [3:0] w_miss_next;

`ifdef WORD_ROUND_CASE_FOLD_EN
    assign w_guess_in = (guess_ascii >= 7'h41 && guess_ascii <= 7'h5A) ?
                        guess_ascii + 7'h20 : guess_ascii;
`else
    assign w_guess_in = guess_ascii;
`endif

    // A set verdict wins over a simultaneous wrong; neither means no match.
    always_comb begin
        w_pos_hit = 1'b0;
        case ({cmp_set, cmp_wrong})
            2'b10, 2'b11: w_pos_hit = 1'b1;
            default:      w_pos_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (r_idx == 3'(i)) w_sel = r_word[7*i +: 7];
        end
    end

    assign w_sample    = (r_state == S_SCAN) && (r_lat_cnt == c_lat_last);
    assign w_all       = &r_revealed;
    assign w_miss_next = (!r_hit && r_miss != c_max_miss) ? r_miss + 4'd1 : r_miss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_EMPTY;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        guess_ready  = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_READY: begin
                guess_ready = 1'b1;
                if (guess_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (w_sample && r_idx == c_idx_last) w_state_next = S_EVAL;
            end
            S_EVAL: begin
                if (w_all)                          w_state_next = S_DONE;
                else if (w_miss_next == c_max_miss) w_state_next = S_DONE;
                else                                w_state_next = S_READY;
            end
            default: w_state_next = r_state;
        endcase
        // A load overrides everything, including a guess offered alongside it.
        if (word_load) begin
            w_state_next = S_READY;
            w_accept     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_guess    <= '0;
            r_idx      <= '0;
            r_lat_cnt  <= '0;
            r_hit      <= 1'b0;
            r_revealed <= '0;
            r_miss     <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
        end else if (word_load) begin
            r_word     <= word_in;
            r_idx      <= '0;
            r_lat_cnt  <= '0;
            r_hit      <= 1'b0;
            r_revealed <= '0;
            r_miss     <= '0;
            r_win      <= 1'b0;
            r_lose     <= 1'b0;
        end else if (w_accept) begin
            r_guess   <= w_guess_in;
            r_idx     <= '0;
            r_lat_cnt <= '0;
            r_hit     <= 1'b0;
        end else if (r_state == S_SCAN) begin
            if (w_sample) begin
                if (w_pos_hit) begin
                    r_hit <= 1'b1;
                    for (int i = 0; i < WORD_LEN; i++) begin
                        if (r_idx == 3'(i)) r_revealed[i] <= 1'b1;
                    end
                end
                r_idx     <= r_idx + 3'd1;
                r_lat_cnt <= '0;
            end else begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end
        end else if (r_state == S_EVAL) begin
            r_miss <= w_miss_next;
            r_win  <= w_all;
            r_lose <= !w_all && (w_miss_next == c_max_miss);
        end
    end

    assign ascii      = (r_state == S_SCAN) ? r_guess : 7'd0;
    assign selection  = (r_state == S_SCAN) ? w_sel   : 7'd0;
    assign revealed   = r_revealed;
    assign miss_count = r_miss;
    assign win        = r_win;
    assign lose       = r_lose;

endmodule
`default_nettype wire
